// File: rtl/vga_text_render.sv
// vga_text_render: text-mode pixel generator driven by the VGA axis counters.
// For each glyph position it reads the character code from text RAM, then the
// glyph row bitmap from font ROM, and selects one bit. active and both syncs are
// delayed through a matched 2-stage ce-qualified pipeline, so video and syncs
// stay aligned at the output.
//
// Optional feature: define VGA_CURSOR_EN to get a blinking underline cursor
// (6-bit frame counter, blink = bit 5) at (cursor_col, cursor_row).
//
// Ports:
//   clk, reset_n            pixel clock, async active-low reset
//   ce                      pixel clock enable (pipeline advances when high)
//   h_active/h_sync/h_glyph/h_pixel   horizontal axis inputs (sync active low)
//   v_active/v_sync/v_glyph/v_pixel   vertical axis inputs (sync active low)
//   mem_ce                  read enable for both memories (= ce)
//   text_addr, text_data    text RAM address (comb.) / character code
//   font_addr, font_data    font ROM address (comb.) / row bitmap, MSB leftmost
//   cursor_col, cursor_row  cursor position (VGA_CURSOR_EN only)
//   video, hsync, vsync     registered pixel and delayed syncs
module vga_text_render #(
  parameter int unsigned COLUMNS     = 80,
  parameter int unsigned ROWS        = 25,
  parameter int unsigned CELL_WIDTH  = 10,
  parameter int unsigned CELL_HEIGHT = 16,
  parameter int unsigned FONT_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  ce,
  input  logic                                  h_active,
  input  logic                                  h_sync,
  input  logic [$clog2(COLUMNS)-1:0]            h_glyph,
  input  logic [$clog2(CELL_WIDTH)-1:0]         h_pixel,
  input  logic                                  v_active,
  input  logic                                  v_sync,
  input  logic [$clog2(ROWS)-1:0]               v_glyph,
  input  logic [$clog2(CELL_HEIGHT)-1:0]        v_pixel,
  output logic                                  mem_ce,
  output logic [$clog2(COLUMNS*ROWS)-1:0]       text_addr,
  input  logic [7:0]                            text_data,
  output logic [8+$clog2(CELL_HEIGHT)-1:0]      font_addr,
  input  logic [FONT_WIDTH-1:0]                 font_data,
  input  logic [$clog2(COLUMNS)-1:0]            cursor_col,
  input  logic [$clog2(ROWS)-1:0]               cursor_row,
  output logic                                  video,
  output logic                                  hsync,
  output logic                                  vsync
);

  localparam int unsigned HPW = $clog2(CELL_WIDTH);
  localparam int unsigned VPW = $clog2(CELL_HEIGHT);
  localparam int unsigned TAW = $clog2(COLUMNS*ROWS);

  // Stage 1: sideband aligned with the text RAM read
  logic           s1_a;
  logic           s1_hs;
  logic           s1_vs;
  logic [HPW-1:0] s1_hp;
  logic [VPW-1:0] s1_vp;

  // Stage 2: sideband aligned with the font ROM read
  logic           s2_a;
  logic           s2_hs;
  logic           s2_vs;
  logic [HPW-1:0] s2_hp;

  logic font_bit_c;
  logic video_c;

  // Both memories read in lock step with the pixel enable
  assign mem_ce = ce;

  // Out-of-range glyphs wrap harmlessly; the active bit gates the pixel
  assign text_addr = TAW'(32'(v_glyph) * 32'(COLUMNS) + 32'(h_glyph));

  assign font_addr = {text_data, s1_vp};

  // Sideband pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_a  <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      s1_hp <= '0;
      s1_vp <= '0;
      s2_a  <= 1'b0;
      s2_hs <= 1'b1;
      s2_vs <= 1'b1;
      s2_hp <= '0;
    end else if (ce) begin
      s1_a  <= h_active & v_active;
      s1_hs <= h_sync;
      s1_vs <= v_sync;
      s1_hp <= h_pixel;
      s1_vp <= v_pixel;
      s2_a  <= s1_a;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_hp <= s1_hp;
    end
  end

  // Bit select: MSB is the leftmost pixel; pixels past FONT_WIDTH form the gap
  always_comb begin
    font_bit_c = 1'b0;
    for (int unsigned i = 0; i < FONT_WIDTH; i++) begin
      if (s2_hp == HPW'(i)) begin
        font_bit_c = font_data[FONT_WIDTH-1-i];
      end
    end
  end

`ifdef VGA_CURSOR_EN
  logic       s1_hit;
  logic       s2_hit;
  logic [5:0] frame_cnt;

  // Cursor hit capture and frame counter (counts sampled v_sync falls)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit    <= 1'b0;
      s2_hit    <= 1'b0;
      frame_cnt <= '0;
    end else if (ce) begin
      s1_hit <= (h_glyph == cursor_col) & (v_glyph == cursor_row) &
                (v_pixel >= VPW'(CELL_HEIGHT-2));
      s2_hit <= s1_hit;
      if (s1_vs && !v_sync) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // Cursor inverts the whole cell width, gap included
  assign video_c = (s2_a & font_bit_c) ^ (s2_hit & s2_a & frame_cnt[5]);
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
  assign video_c       = s2_a & font_bit_c;
`endif

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (ce) begin
      video <= video_c;
      hsync <= s2_hs;
      vsync <= s2_vs;
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: memory stand-ins, a sample-level reference model
// (glyph lookup, pipeline depth of two enabled edges, frame count of v_sync
// falls) and directed plus randomized stimulus.
module tb_vga_text_render;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        h_active, h_sync, v_active, v_sync;
  logic [6:0]  h_glyph, cursor_col;
  logic [3:0]  h_pixel, v_pixel;
  logic [4:0]  v_glyph, cursor_row;
  logic        mem_ce;
  logic [10:0] text_addr;
  logic [7:0]  text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        video, hsync, vsync;

  int checks = 0;
  int errors = 0;

  vga_text_render dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .h_active(h_active), .h_sync(h_sync), .h_glyph(h_glyph), .h_pixel(h_pixel),
    .v_active(v_active), .v_sync(v_sync), .v_glyph(v_glyph), .v_pixel(v_pixel),
    .mem_ce(mem_ce), .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .video(video), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  // Memories: address registered on mem_ce edges, data held otherwise
  logic [7:0] tram [2048];
  logic [7:0] from [4096];
  always @(posedge clk) begin
    if (mem_ce) begin
      text_data <= tram[text_addr];
      font_data <= from[font_addr];
    end
  end

  // Reference model
  typedef struct {
    logic video;
    logic hs;
    logic vs;
    logic hit;
    logic a;
  } exp_t;

  exp_t        pipe[$];
  logic        exp_video, exp_hs, exp_vs;
  int          frame;
  logic        last_vs;
  logic [11:0] exp_faddr;
  bit          have_s1;
  logic        obs[32];

  function automatic int cell_addr();
    return (int'(v_glyph) * 80 + int'(h_glyph)) % 2048;
  endfunction

  function automatic exp_t sample();
    exp_t e;
    logic [7:0] ch;
    logic [7:0] row;
    ch  = tram[cell_addr()];
    row = from[{ch, v_pixel}];
    e.a     = h_active & v_active;
    e.video = e.a && (h_pixel < 8) && row[7 - int'(h_pixel)];
    e.hs    = h_sync;
    e.vs    = v_sync;
    e.hit   = (h_glyph == cursor_col) && (v_glyph == cursor_row) && (v_pixel >= 14);
    return e;
  endfunction

  task automatic model_reset();
    exp_t r;
    r.video = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.hit = 1'b0; r.a = 1'b0;
    pipe = {};
    pipe.push_back(r);
    pipe.push_back(r);
    exp_video = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
    frame = 0; last_vs = 1'b1; have_s1 = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: advance model on enabled edges, then check outputs
  task automatic tick();
    exp_t e;
    exp_t n;
    @(posedge clk);
    if (ce && reset_n) begin
      e = pipe.pop_front();
      exp_video = e.video;
`ifdef VGA_CURSOR_EN
      exp_video = e.video ^ (e.hit & e.a & frame[5]);
`endif
      exp_hs = e.hs;
      exp_vs = e.vs;
      n = sample();
      if (last_vs && !v_sync) frame = (frame + 1) % 64;
      last_vs = v_sync;
      pipe.push_back(n);
      exp_faddr = {tram[cell_addr()], v_pixel};
      have_s1 = 1'b1;
    end
    #1;
    chk("video", 32'(video), 32'(exp_video));
    chk("hsync", 32'(hsync), 32'(exp_hs));
    chk("vsync", 32'(vsync), 32'(exp_vs));
    chk("text_addr", 32'(text_addr), 32'(cell_addr()));
    if (have_s1) chk("font_addr", 32'(font_addr), 32'(exp_faddr));
  endtask

  task automatic rand_in();
    h_active   = ($urandom_range(0, 7) != 0);
    v_active   = ($urandom_range(0, 7) != 0);
    h_sync     = ($urandom_range(0, 5) != 0);
    v_sync     = ($urandom_range(0, 3) != 0);
    h_glyph    = 7'($urandom_range(0, 83));
    h_pixel    = 4'($urandom_range(0, 9));
    v_glyph    = 5'($urandom_range(0, 26));
    v_pixel    = 4'($urandom_range(0, 15));
    cursor_col = 7'($urandom_range(0, 83));
    cursor_row = 5'($urandom_range(0, 26));
  endtask

  task automatic set_cell(input int hg, input int vg, input int hp, input int vp,
                          input logic act);
    h_glyph = 7'(hg); v_glyph = 5'(vg); h_pixel = 4'(hp); v_pixel = 4'(vp);
    h_active = act; v_active = act;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) tram[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) from[i] = 8'($urandom);
    text_data = 8'h00;
    font_data = 8'h00;

    reset_n = 1'b0; ce = 1'b0;
    h_sync = 1'b1; v_sync = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
    set_cell(0, 0, 0, 0, 1'b0);
    model_reset();
    #12;
    chk("rst_video", 32'(video), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    reset_n = 1'b1;

    // Address and font path
    ce = 1'b1;
    set_cell(3, 2, 0, 5, 1'b1);
    tram[163] = 8'h41;
    from[12'h415] = 8'hA0;
    #1;
    chk("text_addr_163", 32'(text_addr), 32'd163);
    for (int k = 0; k < 12; k++) begin
      if (k < 10) h_pixel = 4'(k);
      else set_cell(0, 0, 0, 0, 1'b0);
      tick();
      if (k == 0) chk("font_addr_415", 32'(font_addr), 32'h415);
      obs[k] = video;
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("glyph41_px%0d", k), 32'(obs[k+2]), 32'((k == 0) || (k == 2)));
    end

    // Latency: h_sync fall reaches hsync two enabled edges later
    h_sync = 1'b1;
    tick(); tick();
    h_sync = 1'b0;
    tick();
    chk("lat_hs_e0", 32'(hsync), 32'd1);
    h_sync = 1'b1;
    tick();
    chk("lat_hs_e1", 32'(hsync), 32'd1);
    tick();
    chk("lat_hs_e2", 32'(hsync), 32'd0);
    tick();
    chk("lat_hs_e3", 32'(hsync), 32'd1);

    // Blanking with a fully lit glyph row
    tram[80*4 + 7] = 8'h7F;
    for (int i = 0; i < 16; i++) from[{8'h7F, 4'(i)}] = 8'hFF;
    set_cell(7, 4, 2, 3, 1'b1);
    h_active = 1'b0;
    tick();
    h_active = 1'b1; v_active = 1'b0; v_sync = 1'b0;
    tick();
    h_active = 1'b1; v_active = 1'b1; v_sync = 1'b1;
    tick();
    chk("blank_h", 32'(video), 32'd0);
    tick();
    chk("blank_v", 32'(video), 32'd0);
    chk("blank_vsync", 32'(vsync), 32'd0);
    tick();
    chk("lit_pixel", 32'(video), 32'd1);

    // Random stream, ce every clk
    for (int k = 0; k < 400; k++) begin
      rand_in();
      tick();
    end

    // ce on every third clk
    for (int k = 0; k < 300; k++) begin
      if (k % 3 == 0) rand_in();
      ce = (k % 3 == 0);
      tick();
    end

    // Random ce
    for (int k = 0; k < 300; k++) begin
      rand_in();
      ce = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Reset mid-line, between enabled edges
    ce = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_cell(7, 4, k, 3, 1'b1);
      h_sync = 1'b0; v_sync = 1'b0;
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_video", 32'(video), 32'd0);
    chk("midrst_hsync", 32'(hsync), 32'd1);
    chk("midrst_vsync", 32'(vsync), 32'd1);
    tick();
    reset_n = 1'b1;
    h_sync = 1'b0; v_sync = 1'b1;
    set_cell(7, 4, 0, 3, 1'b1);
    tick();
    chk("post_rst_e1", 32'(hsync), 32'd1);
    tick();
    chk("post_rst_e2", 32'(hsync), 32'd1);
    tick();
    chk("post_rst_e3_hs", 32'(hsync), 32'd0);
    chk("post_rst_e3_vid", 32'(video), 32'd1);
    h_sync = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rand_in();
      tick();
    end

`ifdef VGA_CURSOR_EN
    // Cursor: reset, 32 frame falls, then the cursor cell under a blank glyph
    reset_n = 1'b0;
    #1;
    model_reset();
    #2;
    reset_n = 1'b1;
    ce = 1'b1;
    cursor_col = 7'd3; cursor_row = 5'd2;
    tram[163] = 8'h20;
    for (int i = 0; i < 16; i++) from[{8'h20, 4'(i)}] = 8'h00;
    set_cell(0, 0, 0, 0, 1'b1);
    for (int f = 0; f < 32; f++) begin
      v_sync = 1'b1; tick();
      v_sync = 1'b0; tick();
    end
    v_sync = 1'b1;
    for (int vp = 13; vp < 16; vp++) begin
      for (int k = 0; k < 12; k++) begin
        if (k < 10) set_cell(3, 2, k, vp, 1'b1);
        else set_cell(0, 0, 0, 0, 1'b0);
        tick();
        obs[k] = video;
      end
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("cursor_vp%0d_px%0d", vp, k), 32'(obs[k+2]), 32'(vp >= 14));
      end
    end
    for (int f = 0; f < 32; f++) begin
      v_sync = 1'b1; tick();
      v_sync = 1'b0; tick();
    end
    v_sync = 1'b1;
    set_cell(3, 2, 9, 15, 1'b1);
    tick(); tick(); tick();
    chk("cursor_wrap_off", 32'(video), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
